// File: rtl/input_press_classifier_if.sv
// input_press_classifier_if: debounced edge inputs and classified press events of one button.
interface input_press_classifier_if;
    logic ondn;
    logic onup;
    logic short_press;
    logic long_press;
    logic double_press;
    logic held;
    logic repeat_press;
    modport master(output ondn, onup, input short_press, long_press, double_press, held, repeat_press);
    modport slave(input ondn, onup, output short_press, long_press, double_press, held, repeat_press);
endinterface

// File: rtl/input_press_classifier.sv
// input_press_classifier: turns one button's debounced edges into short/long/double press pulses.
// Optional INPUT_PRESS_REPEAT_EN adds an auto-repeat pulse train while the button is long-held.
module input_press_classifier #(
    parameter int CNT_W        = 28,
    parameter int LONG_TICKS   = 50_000_000,
    parameter int DOUBLE_TICKS = 25_000_000,
    parameter int REPEAT_TICKS = 10_000_000
) (
    input logic clk,
    input logic rst,
    input_press_classifier_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRESSED, WAIT2, PRESS2, HELD} state_t;
    localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_END = CNT_W'(DOUBLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic short_nx, long_nx, double_nx;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        case (state)
            IDLE: if (bus.ondn) begin
                state_nx = PRESSED;
                cnt_nx   = '0;
            end
            PRESSED: begin
                cnt_nx = cnt_inc;
                if (bus.onup) begin
                    state_nx = WAIT2;
                    cnt_nx   = '0;
                end else if (cnt == LONG_END) begin
                    state_nx = HELD;
                    long_nx  = 1'b1;
                end
            end
            WAIT2: begin
                cnt_nx = cnt_inc;
                if (bus.ondn) begin
                    state_nx = PRESS2;
                    cnt_nx   = '0;
                end else if (cnt == DOUBLE_END) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end
            end
            PRESS2: if (bus.onup) begin
                state_nx  = IDLE;
                double_nx = 1'b1;
            end
            HELD: state_nx = bus.onup ? IDLE : HELD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.short_press  <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.double_press <= 1'b0;
            bus.held         <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            bus.short_press  <= short_nx;
            bus.long_press   <= long_nx;
            bus.double_press <= double_nx;
            bus.held         <= (state_nx == HELD);
        end
    end
`ifdef INPUT_PRESS_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_TICKS - 1);
    logic [CNT_W-1:0] rcnt, rcnt_nx;
    logic repeat_nx;
    // rcnt idles at zero outside HELD, so it starts from zero on every entry
    always_comb begin
        rcnt_nx   = (state != HELD || rcnt == REPEAT_END) ? '0 :
                    (rcnt == CNT_MAX) ? rcnt : rcnt + CNT_W'(1);
        repeat_nx = (state == HELD) && !bus.onup && (rcnt == REPEAT_END);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt             <= '0;
            bus.repeat_press <= 1'b0;
        end else begin
            rcnt             <= rcnt_nx;
            bus.repeat_press <= repeat_nx;
        end
    end
`else
    assign bus.repeat_press = 1'b0;
`endif
endmodule
